spi_slv_frame_rx: RTL and testbench

- SPI mode-0 slave front end. It sits directly downstream of the SPI master pins (sclk/csb/mosi) and upstream of the register-access logic.
- It oversamples the SPI pins on the local clock and deserializes one 24-bit frame per chip-select window: {wr, addr[6:0], data[7:0], crc[7:0]}, MSB first.
- It checks the CRC-8 and length, and presents the decoded frame as a one-cycle valid pulse.
- In parallel it shifts a 24-bit response word out on MISO.

---
 rtl/spi_slv_pkg.sv | 20 ++
 rtl/spi_slv_frame_rx_crc.sv | 22 ++
 rtl/spi_slv_frame_rx.sv | 201 ++++++++++++++++++++
 tb/tb_spi_slv_frame_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slv_pkg.sv
// Shared types and frame layout for the SPI mode-0 slave frame receiver.
package spi_slv_pkg;

    localparam int unsigned FRM_W    = 24;

    // Frame layout, MSB first: {wr, addr[6:0], data[7:0], crc[7:0]}
    localparam int unsigned WR_BIT   = 23;
    localparam int unsigned ADDR_MSB = 22;
    localparam int unsigned ADDR_LSB = 16;
    localparam int unsigned DATA_MSB = 15;
    localparam int unsigned DATA_LSB = 8;
    localparam int unsigned CRC_MSB  = 7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRx   = 2'd1,
        StChk  = 2'd2
    } state_e;

endpackage

// File: rtl/spi_slv_frame_rx_crc.sv
// CRC-8 (poly x^8+x^2+x+1, init 0, MSB first) over a 16-bit word, fully combinational.
module crc16to8_parallel (
    input  logic [15:0] i_data,
    output logic [7:0]  o_crc
);

    function automatic logic [7:0] crc8(input logic [15:0] d);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 15; i >= 0; i--) begin
            if (c[7] ^ d[i]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    assign o_crc = crc8(i_data);

endmodule

// File: rtl/spi_slv_frame_rx.sv
// SPI mode-0 slave frame receiver: oversamples sclk/csb/mosi, deserializes one 24-bit
// frame per chip-select window, checks length (and CRC when SPI_SLV_CRC_CHK_EN is
// defined) and shifts a response word out on MISO.
module spi_slv_frame_rx
    import spi_slv_pkg::*;
#(
    parameter int unsigned SYNC_STG  = 2,
    parameter int unsigned BIT_CNT_W = $clog2(FRM_W + 2)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sclk,
    input  logic             i_csb,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic             o_miso_oe,
    input  logic [FRM_W-1:0] i_rsp_data,
    output logic             o_frm_vld,
    output logic             o_wr,
    output logic [6:0]       o_addr,
    output logic [7:0]       o_wdata,
    output logic             o_crc_err,
    output logic             o_len_err,
    output logic [7:0]       o_frm_cnt
);

    localparam int unsigned FLUSH_W = $clog2(SYNC_STG + 1);

    logic [SYNC_STG-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STG-1:0]  csb_sync_q, csb_sync_d;
    logic [SYNC_STG-1:0]  mosi_sync_q, mosi_sync_d;
    logic                 sclk_dly_q, sclk_dly_d;
    logic                 csb_dly_q, csb_dly_d;
    logic                 mosi_dly_q, mosi_dly_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;
    logic                 armed_q, armed_d;
    state_e               state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [FRM_W-1:0]     rx_sr_q, rx_sr_d;
    logic [FRM_W-1:0]     tx_sr_q, tx_sr_d;
    logic                 miso_q, miso_d;
    logic                 frm_vld_q, frm_vld_d;
    logic                 wr_q, wr_d;
    logic [6:0]           addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic                 crc_err_q, crc_err_d;
    logic                 len_err_q, len_err_d;
    logic [7:0]           frm_cnt_q, frm_cnt_d;

    logic sclk_s, csb_s;
    logic sclk_rise, sclk_fall, csb_rise;
    logic flushed;
    logic crc_bad;

    assign sclk_s    = sclk_sync_q[SYNC_STG-1];
    assign csb_s     = csb_sync_q[SYNC_STG-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign csb_rise  = csb_s & ~csb_dly_q;
    // csb_s still shows its reset value until the chain has refilled from the pin.
    assign flushed   = (flush_q == FLUSH_W'(SYNC_STG));

`ifdef SPI_SLV_CRC_CHK_EN
    logic [7:0] crc_calc;

    crc16to8_parallel u_crc (
        .i_data (rx_sr_q[FRM_W-1:DATA_LSB]),
        .o_crc  (crc_calc)
    );

    assign crc_bad = (rx_sr_q[CRC_MSB:0] != crc_calc);
`else
    assign crc_bad = 1'b0;
`endif

    // Next-state for synchronizers, arming and the IDLE/RX/CHK frame FSM.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STG-2:0], i_sclk};
        csb_sync_d  = {csb_sync_q[SYNC_STG-2:0], i_csb};
        mosi_sync_d = {mosi_sync_q[SYNC_STG-2:0], i_mosi};
        sclk_dly_d  = sclk_s;
        csb_dly_d   = csb_s;
        mosi_dly_d  = mosi_sync_q[SYNC_STG-1];
        flush_d     = flushed ? flush_q : flush_q + FLUSH_W'(1);
        armed_d     = armed_q | (flushed & csb_s);
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        miso_d      = miso_q;
        frm_vld_d   = 1'b0;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        crc_err_d   = crc_err_q;
        len_err_d   = 1'b0;
        frm_cnt_d   = frm_cnt_q;

        unique case (state_q)
            StIdle: begin
                // Level check so a csb fall that landed during CHK is still taken.
                if (armed_q && !csb_s) begin
                    state_d   = StRx;
                    bit_cnt_d = '0;
                    tx_sr_d   = i_rsp_data;
                    miso_d    = i_rsp_data[FRM_W-1];
                end
            end
            StRx: begin
                // csb_rise has priority over a coincident sclk edge.
                if (csb_rise) begin
                    miso_d = 1'b0;
                    if (bit_cnt_q == BIT_CNT_W'(FRM_W)) begin
                        state_d = StChk;
                    end else begin
                        len_err_d = 1'b1;
                        state_d   = StIdle;
                    end
                end else if (sclk_rise) begin
                    rx_sr_d = {rx_sr_q[FRM_W-2:0], mosi_dly_q};
                    if (bit_cnt_q != BIT_CNT_W'(FRM_W + 1)) begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    tx_sr_d = {tx_sr_q[FRM_W-2:0], 1'b0};
                    miso_d  = tx_sr_q[FRM_W-2];
                end
            end
            StChk: begin
                frm_vld_d = 1'b1;
                wr_d      = rx_sr_q[WR_BIT];
                addr_d    = rx_sr_q[ADDR_MSB:ADDR_LSB];
                wdata_d   = rx_sr_q[DATA_MSB:DATA_LSB];
                crc_err_d = crc_bad;
                if (!crc_bad) begin
                    frm_cnt_d = frm_cnt_q + 8'd1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sclk_sync_q <= '0;
            csb_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            csb_dly_q   <= 1'b1;
            mosi_dly_q  <= 1'b0;
            flush_q     <= '0;
            armed_q     <= 1'b0;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            miso_q      <= 1'b0;
            frm_vld_q   <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            crc_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            frm_cnt_q   <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            csb_sync_q  <= csb_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            csb_dly_q   <= csb_dly_d;
            mosi_dly_q  <= mosi_dly_d;
            flush_q     <= flush_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            miso_q      <= miso_d;
            frm_vld_q   <= frm_vld_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            crc_err_q   <= crc_err_d;
            len_err_q   <= len_err_d;
            frm_cnt_q   <= frm_cnt_d;
        end
    end

    assign o_miso    = miso_q;
    assign o_miso_oe = (state_q == StRx) & ~csb_s;
    assign o_frm_vld = frm_vld_q;
    assign o_wr      = wr_q;
    assign o_addr    = addr_q;
    assign o_wdata   = wdata_q;
    assign o_crc_err = crc_err_q;
    assign o_len_err = len_err_q;
    assign o_frm_cnt = frm_cnt_q;

endmodule

// File: tb/tb_spi_slv_frame_rx.sv
// Bench for spi_slv_frame_rx: an SPI master task drives frames at sclk = clk/8 and
// queues what each chip-select window must produce; a per-cycle compare process
// checks the DUT pulses, fields and counter against that queue.
module tb_spi_slv_frame_rx;

`ifdef SPI_SLV_CRC_CHK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n, i_sclk, i_csb, i_mosi;
    logic [23:0] i_rsp_data;
    logic        o_miso, o_miso_oe, o_frm_vld, o_wr, o_crc_err, o_len_err;
    logic [6:0]  o_addr;
    logic [7:0]  o_wdata, o_frm_cnt;

    spi_slv_frame_rx dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_sclk     (i_sclk),
        .i_csb      (i_csb),
        .i_mosi     (i_mosi),
        .o_miso     (o_miso),
        .o_miso_oe  (o_miso_oe),
        .i_rsp_data (i_rsp_data),
        .o_frm_vld  (o_frm_vld),
        .o_wr       (o_wr),
        .o_addr     (o_addr),
        .o_wdata    (o_wdata),
        .o_crc_err  (o_crc_err),
        .o_len_err  (o_len_err),
        .o_frm_cnt  (o_frm_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [23:0] frm;
        bit          len_ok;
        longint      ts;
    } ev_t;

    ev_t    exp_q[$];
    int     n_tests = 0;
    int     n_fail  = 0;
    int     n_vld   = 0;

    // Model of the held outputs.
    logic        m_wr = 1'b0;
    logic [6:0]  m_addr = '0;
    logic [7:0]  m_wdata = '0;
    logic [7:0]  m_cnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte-oriented CRC-8, poly 0x07, init 0.
    function automatic logic [7:0] ref_crc(input logic [15:0] d);
        logic [7:0] c;
        logic [7:0] bytes [2];
        c = 8'h00;
        bytes[0] = d[15:8];
        bytes[1] = d[7:0];
        for (int k = 0; k < 2; k++) begin
            c = c ^ bytes[k];
            for (int j = 0; j < 8; j++) begin
                c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
            end
        end
        return c;
    endfunction

    function automatic logic [23:0] mk_frame(input logic [15:0] hdr, input bit good);
        logic [7:0] crc;
        crc = ref_crc(hdr);
        if (!good) crc = crc ^ 8'($urandom_range(1, 255));
        return {hdr, crc};
    endfunction

    // One chip-select window of nbits sclk pulses; rst_bit >= 0 pulses reset at that bit.
    task automatic send(input logic [23:0] frm, input int nbits, input int rst_bit,
                        input logic [23:0] rsp);
        logic [23:0] cap;
        ev_t         e;
        cap = '0;
        i_rsp_data = rsp;
        chk("idle_miso_oe", {o_miso_oe, o_miso}, 2'b00);
        i_csb = 1'b0;
        #40;
        for (int b = 0; b < nbits; b++) begin
            if (b == rst_bit) begin
                i_rst_n = 1'b0;
                #30;
                i_rst_n = 1'b1;
            end
            i_mosi = (b < 24) ? frm[23-b] : 1'b0;
            #40;
            cap = {cap[22:0], o_miso};
            if (rst_bit < 0) chk("miso_oe_window", o_miso_oe, 1'b1);
            i_sclk = 1'b1;
            #40;
            i_sclk = 1'b0;
        end
        #40;
        i_csb = 1'b1;
        if (rst_bit < 0) begin
            e.frm    = frm;
            e.len_ok = (nbits == 24);
            e.ts     = $time;
            exp_q.push_back(e);
        end
        #320;
        if (nbits == 24 && rst_bit < 0) chk("miso_shift", cap, rsp);
    endtask

    // Per-cycle compare against the queued expectations.
    always @(negedge i_clk) begin
        ev_t        e;
        logic       exp_err;
        if (!i_rst_n) begin
            m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_cnt = '0;
            exp_q.delete();
            chk("reset_outputs", {o_frm_vld, o_len_err, o_crc_err, o_miso, o_miso_oe,
                                  o_wr, o_addr, o_wdata, o_frm_cnt}, '0);
        end else begin
            if (o_frm_vld || o_len_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {o_frm_vld, o_len_err}, 2'b00);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_kind", {o_frm_vld, o_len_err}, e.len_ok ? 2'b10 : 2'b01);
                    chk("pulse_latency", $time - e.ts, e.len_ok ? 38 : 28);
                    if (e.len_ok) begin
                        exp_err = CRC_EN && (ref_crc(e.frm[23:8]) != e.frm[7:0]);
                        m_wr    = e.frm[23];
                        m_addr  = e.frm[22:16];
                        m_wdata = e.frm[15:8];
                        if (!exp_err) m_cnt = m_cnt + 8'd1;
                        n_vld++;
                        chk("crc_err", o_crc_err, exp_err);
                    end
                end
            end
            chk("fields", {o_wr, o_addr, o_wdata}, {m_wr, m_addr, m_wdata});
            chk("frm_cnt", o_frm_cnt, m_cnt);
        end
    end

    initial begin
        int          v0;
        int          r;
        int          len;
        logic [23:0] f;
        i_rst_n = 1'b0; i_sclk = 1'b0; i_csb = 1'b1; i_mosi = 1'b0; i_rsp_data = '0;
        #2;
        #50;
        i_rst_n = 1'b1;
        #100;
        chk("reset_frm_cnt", o_frm_cnt, 8'd0);
        chk("crc_ref_pin", ref_crc(16'hC05B), 8'h6B);

        // Good write frame.
        send(mk_frame(16'hC05B, 1'b1), 24, -1, 24'($urandom));
        chk("wr_frame_wr", o_wr, 1'b1);
        chk("wr_frame_addr", o_addr, 7'h40);
        chk("wr_frame_wdata", o_wdata, 8'h5B);
        chk("wr_frame_cnt", o_frm_cnt, 8'd1);

        // Read frame with a known response word.
        send(mk_frame({1'b0, 7'h6E, 8'h00}, 1'b1), 24, -1, 24'hA5C3F0);
        chk("rd_frame_addr", o_addr, 7'h6E);
        chk("rd_frame_cnt", o_frm_cnt, 8'd2);

        // CRC error: crc bit 0 flipped.
        send({16'hC05B, 8'h6A}, 24, -1, 24'($urandom));
        chk("crc_err_cnt", o_frm_cnt, CRC_EN ? 8'd2 : 8'd3);

        // Length errors and a zero-pulse glitch; fields must hold.
        send(mk_frame(16'h1234, 1'b1), 23, -1, 24'($urandom));
        send(mk_frame(16'h1234, 1'b1), 25, -1, 24'($urandom));
        send(mk_frame(16'h1234, 1'b1), 0, -1, 24'($urandom));
        chk("len_err_addr_held", o_addr, 7'h40);
        chk("len_err_wdata_held", o_wdata, 8'h5B);

        // Reset mid-frame, then a full frame.
        send(mk_frame(16'hFFFF, 1'b1), 24, 10, 24'($urandom));
        chk("mid_reset_cnt", o_frm_cnt, 8'd0);
        send(mk_frame(16'h8A3C, 1'b1), 24, -1, 24'($urandom));
        chk("post_reset_addr", o_addr, 7'h0A);
        chk("post_reset_cnt", o_frm_cnt, 8'd1);

        // Randomized mix.
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(0, 9);
            f = mk_frame(16'($urandom), r < 6);
            len = 24;
            if (r == 0) begin
                len = $urandom_range(0, 26);
                if (len == 24) len = 27;
            end
            send(f, len, -1, 24'($urandom));
        end

        // Counter wrap: 256 good frames from reset.
        i_rst_n = 1'b0;
        #30;
        i_rst_n = 1'b1;
        #100;
        v0 = n_vld;
        for (int i = 0; i < 256; i++) begin
            send(mk_frame(16'($urandom), 1'b1), 24, -1, 24'($urandom));
        end
        chk("wrap_cnt", o_frm_cnt, 8'd0);
        chk("wrap_vld_count", n_vld - v0, 256);

        #1000;
        chk("missing_events", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
